// File: rtl/nor_gate_core.sv
// rtl/nor_gate_core.sv - bitwise NOR cell with registered outputs; NOR_GATE_HA_EN adds a NOR-built half adder
module nor_gate_core #(
  parameter int WIDTH = 1
) (
  output logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             out_valid,
  output logic [WIDTH-1:0] y_q,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q
);

  // The one primitive every lane is built from.
  function automatic logic [WIDTH-1:0] nor_f(input logic [WIDTH-1:0] p,
                                             input logic [WIDTH-1:0] q);
    return ~(p | q);
  endfunction

  // Combinational result; never touched by clock or reset.
  assign y = nor_f(a, b);

  // Capture the NOR result on valid input, hold otherwise; out_valid marks a fresh capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y_q <= y;
      end
    end
  end

`ifdef NOR_GATE_HA_EN
  logic [WIDTH-1:0] na;
  logic [WIDTH-1:0] nb;
  logic [WIDTH-1:0] carry_d;
  logic [WIDTH-1:0] sum_d;

  // Half adder from NOR only: inverters are self-NORs, carry = a&b, sum = a^b.
  assign na      = nor_f(a, a);
  assign nb      = nor_f(b, b);
  assign carry_d = nor_f(na, nb);
  assign sum_d   = nor_f(carry_d, y);

  // Half-adder results share the capture/hold behaviour of y_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= '0;
    end else if (in_valid) begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end
`else
  assign sum_q   = '0;
  assign carry_q = '0;
`endif

endmodule

// File: tb/tb_nor_gate_core.sv
// tb/tb_nor_gate_core.sv - self-checking bench for nor_gate_core (WIDTH=1 and WIDTH=8)
module tb_nor_gate_core;

`ifdef NOR_GATE_HA_EN
  localparam bit HA = 1'b1;
`else
  localparam bit HA = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [0:0] a1 = '0, b1 = '0, y1, yq1, s1, c1;
  logic       iv1 = 1'b0, ov1;
  logic [7:0] a8 = '0, b8 = '0, y8, yq8, s8, c8;
  logic       iv8 = 1'b0, ov8;

  int pass_cnt = 0;
  int total = 0;

  logic [7:0] exp_yq, exp_sum, exp_carry;
  logic       exp_valid;

  nor_gate_core #(.WIDTH(1)) u1 (
    .y(y1), .a(a1), .b(b1), .clk(clk), .rst_n(rst_n), .in_valid(iv1),
    .out_valid(ov1), .y_q(yq1), .sum_q(s1), .carry_q(c1)
  );

  nor_gate_core #(.WIDTH(8)) u8 (
    .y(y8), .a(a8), .b(b8), .clk(clk), .rst_n(rst_n), .in_valid(iv8),
    .out_valid(ov8), .y_q(yq8), .sum_q(s8), .carry_q(c8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
  endtask

  // Per-lane arithmetic view: a lane adds two bits; y is "sum of bits is zero".
  task automatic model_eval(input logic [7:0] pa, input logic [7:0] pb,
                            output logic [7:0] ey, output logic [7:0] es,
                            output logic [7:0] ec);
    for (int i = 0; i < 8; i++) begin
      int s;
      s = int'(pa[i]) + int'(pb[i]);
      ey[i] = (s == 0);
      es[i] = HA ? ((s % 2) == 1) : 1'b0;
      ec[i] = HA ? ((s / 2) == 1) : 1'b0;
    end
  endtask

  task automatic check_all();
    chk("y_q8", yq8, exp_yq);
    chk("sum_q8", s8, exp_sum);
    chk("carry_q8", c8, exp_carry);
    chk("out_valid8", ov8, exp_valid);
  endtask

  logic [1:0] ha_a [4];
  logic [1:0] ha_b [4];
  logic       ha_s [4];
  logic       ha_c [4];
  logic       ha_y [4];

  initial begin
    logic [7:0] ey, es, ec;
    ha_a = '{0, 0, 1, 1};
    ha_b = '{0, 1, 0, 1};
    ha_y = '{1, 0, 0, 0};
    ha_s = '{0, 1, 1, 0};
    ha_c = '{0, 0, 0, 1};

    // Reset state
    #1;
    chk("rst_y_q1", yq1, 0);
    chk("rst_out_valid1", ov1, 0);
    chk("rst_y_q8", yq8, 0);
    chk("rst_sum_q8", s8, 0);
    chk("rst_carry_q8", c8, 0);
    chk("rst_out_valid8", ov8, 0);

    // Combinational truth table, no clock dependence (reset still held)
    for (int k = 0; k < 4; k++) begin
      a1 = ha_a[k][0];
      b1 = ha_b[k][0];
      #1;
      chk("truth_y1", y1, ha_y[k]);
    end

    @(negedge clk);
    rst_n = 1'b1;

    // Half adder stream on consecutive cycles
    a1 = ha_a[0][0]; b1 = ha_b[0][0]; iv1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("ha_y_q1", yq1, ha_y[k]);
      chk("ha_sum_q1", s1, HA ? ha_s[k] : 1'b0);
      chk("ha_carry_q1", c1, HA ? ha_c[k] : 1'b0);
      chk("ha_out_valid1", ov1, 1);
      if (k < 3) begin
        a1 = ha_a[k+1][0]; b1 = ha_b[k+1][0];
      end
    end

    // Hold after capture of 1,1
    iv1 = 1'b0; a1 = 0; b1 = 0;
    #1;
    chk("hold_y1", y1, 1);
    @(negedge clk);
    chk("hold_y_q1", yq1, 0);
    chk("hold_carry_q1", c1, HA ? 1 : 0);
    chk("hold_sum_q1", s1, 0);
    chk("hold_out_valid1", ov1, 0);

    // Async reset mid-cycle after capturing a=1,b=0
    a1 = 1; b1 = 0; iv1 = 1'b1;
    @(posedge clk);
    #2;
    iv1 = 1'b0;
    chk("pre_rst_sum_q1", s1, HA ? 1 : 0);
    chk("pre_rst_out_valid1", ov1, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_y_q1", yq1, 0);
    chk("arst_sum_q1", s1, 0);
    chk("arst_carry_q1", c1, 0);
    chk("arst_out_valid1", ov1, 0);
    chk("arst_y1", y1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Multi-lane literal
    a8 = 8'hF0; b8 = 8'h3C; iv8 = 1'b1;
    #1;
    chk("lane_y8", y8, 8'h03);
    @(negedge clk);
    chk("lane_y_q8", yq8, 8'h03);
    chk("lane_sum_q8", s8, HA ? 8'hCC : 8'h00);
    chk("lane_carry_q8", c8, HA ? 8'h30 : 8'h00);
    chk("lane_out_valid8", ov8, 1);
    iv8 = 1'b0;

    // Pin the model to the literal above, then hand it the random run
    model_eval(8'hF0, 8'h3C, ey, es, ec);
    chk("model_y", ey, 8'h03);
    chk("model_sum", es, HA ? 8'hCC : 8'h00);
    chk("model_carry", ec, HA ? 8'h30 : 8'h00);
    exp_yq = ey; exp_sum = es; exp_carry = ec; exp_valid = 1'b1;

    // Randomized run against the model, with occasional mid-cycle resets
    for (int n = 0; n < 400; n++) begin
      check_all();
      if ($urandom_range(0, 15) == 0) begin
        rst_n = 1'b0;
        #1;
        exp_yq = '0; exp_sum = '0; exp_carry = '0; exp_valid = 1'b0;
        check_all();
        #1;
        rst_n = 1'b1;
      end
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      iv8 = ($urandom_range(0, 3) != 0);
      #1;
      model_eval(a8, b8, ey, es, ec);
      chk("rand_y8", y8, ey);
      @(posedge clk);
      if (iv8) begin
        exp_yq = ey; exp_sum = es; exp_carry = ec;
      end
      exp_valid = iv8;
      @(negedge clk);
    end
    check_all();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
